hazard_scoreboard: RTL and testbench

- Producer-side companion to the bypass/forwarding logic: tracks destinations that are not yet forwardable and generates pipeline stalls.
- It owns the in-flight multiply/divide destination (md_rd), load-use interlock and the writeback-port slot for multdiv results.
- Sits between decode (F/D latch) and execute (D/X latch) and drives the global stall consumed by the PC, F/D and D/X latches.

---
 rtl/hazard_scoreboard_pkg.sv | 26 ++
 rtl/hazard_scoreboard_if.sv | 47 ++++
 rtl/hazard_scoreboard_reg_hazard_cmp.sv | 21 ++
 rtl/hazard_scoreboard.sv | 136 +++++++++++++
 tb/tb_hazard_scoreboard.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared definitions for the decode-side hazard scoreboard: register file
// geometry, the multdiv tracking states and a one-hot register helper.
package proc_defs;

    localparam int REG_W    = 5;
    localparam int NUM_REGS = 32;

    localparam logic [REG_W-1:0] STATUS_REG = 5'd30;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        MD_RUN = 2'b01,
        MD_WB  = 2'b10
    } md_state_t;

    // Register 0 is hardwired, so it never maps to a pending bit.
    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_W-1:0] r);
        logic [NUM_REGS-1:0] v;
        v = '0;
        if (r != '0) begin
            v[r] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode/execute pipeline signals seen by the hazard scoreboard, plus the
// multdiv unit handshake; master is the pipeline side, slave the scoreboard.
interface hazard_scoreboard_if;
    import proc_defs::*;

    logic                dx_valid;
    logic [REG_W-1:0]    dx_rd;
    logic                dx_is_lw;
    logic                dx_is_muldiv;
    logic [REG_W-1:0]    fd_rs;
    logic [REG_W-1:0]    fd_rt;
    logic                fd_uses_rs;
    logic                fd_uses_rt;
    logic                fd_is_bex;
    logic                fd_is_muldiv;
    logic [REG_W-1:0]    fd_rd;
    logic                fd_writes;
    // md_result_rdy is a single-cycle pulse; md_exception is meaningful only
    // while md_result_rdy is high. md_start is a single-cycle pulse back.
    logic                md_result_rdy;
    logic                md_exception;
    logic                stall;
    logic                md_start;
    logic                md_busy;
    logic [REG_W-1:0]    md_rd;
    logic                md_wb_valid;
    logic                md_timeout_err;
    logic [NUM_REGS-1:0] pending;
    md_state_t           state;

    modport master (
        output dx_valid, dx_rd, dx_is_lw, dx_is_muldiv,
        output fd_rs, fd_rt, fd_uses_rs, fd_uses_rt, fd_is_bex, fd_is_muldiv,
        output fd_rd, fd_writes, md_result_rdy, md_exception,
        input  stall, md_start, md_busy, md_rd, md_wb_valid, md_timeout_err,
        input  pending, state
    );

    modport slave (
        input  dx_valid, dx_rd, dx_is_lw, dx_is_muldiv,
        input  fd_rs, fd_rt, fd_uses_rs, fd_uses_rt, fd_is_bex, fd_is_muldiv,
        input  fd_rd, fd_writes, md_result_rdy, md_exception,
        output stall, md_start, md_busy, md_rd, md_wb_valid, md_timeout_err,
        output pending, state
    );

endinterface

// File: rtl/hazard_scoreboard_reg_hazard_cmp.sv
// Checks one F/D source register against the multdiv pending vector and
// against a load still sitting in D/X.
module reg_hazard_cmp
    import proc_defs::*;
(
    input  logic [REG_W-1:0]    src,
    input  logic                used,
    input  logic [NUM_REGS-1:0] pending,
    input  logic                lw_valid,
    input  logic [REG_W-1:0]    lw_rd,
    output logic                pending_hit,
    output logic                load_use_hit
);

    logic live;

    assign live         = used && (src != '0);
    assign pending_hit  = live && pending[src];
    assign load_use_hit = live && lw_valid && (src == lw_rd);

endmodule

// File: rtl/hazard_scoreboard.sv
// Tracks the in-flight multiply/divide destination and raises the global
// pipeline stall for load-use, multdiv RAW/WAW/structural and writeback.
module hazard_scoreboard
    import proc_defs::*;
#(
    parameter  int MD_TIMEOUT = 40,
    localparam int CNT_W      = $clog2(MD_TIMEOUT + 1)
) (
    input  logic                 clock,
    input  logic                 reset,
    hazard_scoreboard_if.slave   bus
);

    md_state_t           state;
    md_state_t           state_next;
    logic [CNT_W-1:0]    counter;
    logic [CNT_W-1:0]    counter_inc;
    logic [REG_W-1:0]    md_rd_q;
    logic [NUM_REGS-1:0] pending_q;
    logic                start_q;
    logic                err_q;

    logic lw_valid;
    logic pd_rs, pd_rt, pd_bex;
    logic lu_rs, lu_rt, lu_bex;
    logic load_use, src_pending, waw, md_stall, stall;
    logic rdy_take, start_go, timeout_hit;

    assign lw_valid = bus.dx_valid && bus.dx_is_lw;

    reg_hazard_cmp u_cmp_rs (
        .src(bus.fd_rs), .used(bus.fd_uses_rs), .pending(pending_q),
        .lw_valid(lw_valid), .lw_rd(bus.dx_rd),
        .pending_hit(pd_rs), .load_use_hit(lu_rs)
    );

    reg_hazard_cmp u_cmp_rt (
        .src(bus.fd_rt), .used(bus.fd_uses_rt), .pending(pending_q),
        .lw_valid(lw_valid), .lw_rd(bus.dx_rd),
        .pending_hit(pd_rt), .load_use_hit(lu_rt)
    );

    // bex implicitly reads the status register.
    reg_hazard_cmp u_cmp_bex (
        .src(STATUS_REG), .used(bus.fd_is_bex), .pending(pending_q),
        .lw_valid(lw_valid), .lw_rd(bus.dx_rd),
        .pending_hit(pd_bex), .load_use_hit(lu_bex)
    );

    assign load_use    = lu_rs | lu_rt | lu_bex;
    assign src_pending = pd_rs | pd_rt | pd_bex;
    assign waw         = bus.fd_writes && (bus.fd_rd != '0) && (bus.fd_rd == md_rd_q);
    assign counter_inc = counter + CNT_W'(1);
    // A result arriving in the start-pulse cycle cannot belong to this operation.
    assign rdy_take    = bus.md_result_rdy && !start_q;

    always_comb begin
        md_stall = 1'b0;
        case (state)
            MD_RUN:  md_stall = src_pending | bus.fd_is_muldiv | waw;
            MD_WB:   md_stall = 1'b1;
            default: md_stall = 1'b0;
        endcase
    end

    assign stall = load_use | md_stall;

    always_comb begin
        state_next  = state;
        start_go    = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (bus.dx_valid && bus.dx_is_muldiv && !stall) begin
                    state_next = MD_RUN;
                    start_go   = 1'b1;
                end
            end
            MD_RUN: begin
                if (rdy_take) begin
                    state_next = MD_WB;
                end else if (counter_inc == CNT_W'(MD_TIMEOUT)) begin
                    state_next  = IDLE;
                    timeout_hit = 1'b1;
                end
            end
            MD_WB:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            counter   <= '0;
            md_rd_q   <= '0;
            pending_q <= '0;
            start_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state   <= state_next;
            start_q <= start_go;
            case (state)
                IDLE: begin
                    if (start_go) begin
                        md_rd_q   <= bus.dx_rd;
                        pending_q <= pending_q | reg_onehot(bus.dx_rd);
                        counter   <= '0;
                    end
                end
                MD_RUN: begin
                    counter <= counter_inc;
                    if (rdy_take && bus.md_exception) begin
                        md_rd_q   <= STATUS_REG;
                        pending_q <= (pending_q & ~reg_onehot(md_rd_q)) | reg_onehot(STATUS_REG);
                    end else if (timeout_hit) begin
                        pending_q <= '0;
                        err_q     <= 1'b1;
                    end
                end
                MD_WB:   pending_q <= pending_q & ~reg_onehot(md_rd_q);
                default: ;
            endcase
        end
    end

    assign bus.stall          = stall;
    assign bus.md_start       = start_q;
    assign bus.md_busy        = (state != IDLE);
    assign bus.md_rd          = md_rd_q;
    assign bus.md_wb_valid    = (state == MD_WB);
    assign bus.md_timeout_err = err_q;
    assign bus.pending        = pending_q;
    assign bus.state          = state;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: load-use vector table, directed multdiv
// sequences and randomized traffic against a behavioural model.
module tb_hazard_scoreboard;
    import proc_defs::*;

    localparam int MD_TIMEOUT = 40;

    logic clock = 1'b0;
    logic reset;

    hazard_scoreboard_if bus();

    hazard_scoreboard #(.MD_TIMEOUT(MD_TIMEOUT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_tests = 0;
    int n_fail  = 0;
    logic [0:0] exp_q[$];

    // Behavioural model of the scoreboard.
    bit m_busy, m_wb, m_start, m_err, m_stall;
    int m_age, m_rd;
    bit m_pend[NUM_REGS];

    typedef struct {
        bit dx_valid; int dx_rd; bit dx_is_lw;
        int fd_rs; bit uses_rs; int fd_rt; bit uses_rt; bit is_bex;
        bit exp_stall;
    } lu_vec_t;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.dx_valid = 0; bus.dx_rd = '0; bus.dx_is_lw = 0; bus.dx_is_muldiv = 0;
        bus.fd_rs = '0; bus.fd_rt = '0; bus.fd_uses_rs = 0; bus.fd_uses_rt = 0;
        bus.fd_is_bex = 0; bus.fd_is_muldiv = 0; bus.fd_rd = '0; bus.fd_writes = 0;
        bus.md_result_rdy = 0; bus.md_exception = 0;
    endtask

    task automatic set_dx(bit v, int rd, bit lw, bit md);
        bus.dx_valid = v; bus.dx_rd = REG_W'(rd); bus.dx_is_lw = lw; bus.dx_is_muldiv = md;
    endtask

    task automatic set_fd(int rs, bit urs, int rt, bit urt, bit bex, bit md, int rd, bit wr);
        bus.fd_rs = REG_W'(rs); bus.fd_uses_rs = urs; bus.fd_rt = REG_W'(rt); bus.fd_uses_rt = urt;
        bus.fd_is_bex = bex; bus.fd_is_muldiv = md; bus.fd_rd = REG_W'(rd); bus.fd_writes = wr;
    endtask

    task automatic set_md(bit rdy, bit exc);
        bus.md_result_rdy = rdy; bus.md_exception = exc;
    endtask

    function automatic bit fd_reads(int r);
        return (r != 0) && ((bus.fd_uses_rs && int'(bus.fd_rs) == r) ||
                            (bus.fd_uses_rt && int'(bus.fd_rt) == r) ||
                            (bus.fd_is_bex && r == int'(STATUS_REG)));
    endfunction

    function automatic bit model_stall();
        bit s;
        s = bus.dx_valid && bus.dx_is_lw && fd_reads(int'(bus.dx_rd));
        if (m_wb) begin
            s = 1;
        end else if (m_busy) begin
            for (int r = 1; r < NUM_REGS; r++) begin
                if (m_pend[r] && fd_reads(r)) s = 1;
            end
            if (bus.fd_is_muldiv) s = 1;
            if (bus.fd_writes && bus.fd_rd != '0 && int'(bus.fd_rd) == m_rd) s = 1;
        end
        return s;
    endfunction

    function automatic logic [31:0] pend_vec();
        logic [31:0] v;
        v = '0;
        for (int r = 0; r < NUM_REGS; r++) v[r] = m_pend[r];
        return v;
    endfunction

    task automatic model_step();
        if (reset) begin
            m_busy = 0; m_wb = 0; m_start = 0; m_err = 0; m_age = 0; m_rd = 0;
            foreach (m_pend[i]) m_pend[i] = 0;
        end else if (m_wb) begin
            m_pend[m_rd] = 0;
            m_wb = 0;
            m_busy = 0;
        end else if (m_busy) begin
            m_age++;
            if (bus.md_result_rdy && !m_start) begin
                if (bus.md_exception) begin
                    m_pend[m_rd] = 0;
                    m_rd = int'(STATUS_REG);
                    m_pend[m_rd] = 1;
                end
                m_wb = 1;
            end else if (m_age >= MD_TIMEOUT) begin
                m_busy = 0;
                m_err = 1;
                foreach (m_pend[i]) m_pend[i] = 0;
            end
            m_start = 0;
        end else if (bus.dx_valid && bus.dx_is_muldiv && !m_stall) begin
            m_busy = 1; m_start = 1; m_age = 0; m_rd = int'(bus.dx_rd);
            if (m_rd != 0) m_pend[m_rd] = 1;
        end
    endtask

    // Compare all outputs at the falling edge, then advance DUT and model together.
    task automatic cycle_check(string tag);
        @(negedge clock);
        m_stall = model_stall();
        check({tag, " stall"},   32'(bus.stall),          32'(m_stall));
        check({tag, " busy"},    32'(bus.md_busy),        32'(m_busy));
        check({tag, " start"},   32'(bus.md_start),       32'(m_start));
        check({tag, " wb"},      32'(bus.md_wb_valid),    32'(m_wb));
        check({tag, " md_rd"},   32'(bus.md_rd),          32'(m_rd));
        check({tag, " pending"}, bus.pending,             pend_vec());
        check({tag, " err"},     32'(bus.md_timeout_err), 32'(m_err));
        @(posedge clock);
        model_step();
        #1;
    endtask

    lu_vec_t vecs[9];
    int quiet;

    initial begin
        vecs[0] = '{1, 5, 1,  5, 1, 1, 1, 0, 1};
        vecs[1] = '{1, 0, 1,  0, 1, 0, 1, 0, 0};
        vecs[2] = '{1, 5, 1,  2, 1, 5, 1, 0, 1};
        vecs[3] = '{1, 5, 1,  2, 1, 5, 0, 0, 0};
        vecs[4] = '{1, 30, 1, 0, 0, 0, 0, 1, 1};
        vecs[5] = '{1, 29, 1, 0, 0, 0, 0, 1, 0};
        vecs[6] = '{0, 5, 1,  5, 1, 0, 0, 0, 0};
        vecs[7] = '{1, 5, 0,  5, 1, 0, 0, 0, 0};
        vecs[8] = '{1, 12, 1, 3, 1, 4, 1, 0, 0};

        reset = 1;
        idle_inputs();
        @(posedge clock);
        @(posedge clock);
        model_step();
        #1;
        check("rst stall",   32'(bus.stall), 0);
        check("rst busy",    32'(bus.md_busy), 0);
        check("rst start",   32'(bus.md_start), 0);
        check("rst wb",      32'(bus.md_wb_valid), 0);
        check("rst md_rd",   32'(bus.md_rd), 0);
        check("rst pending", bus.pending, 0);
        check("rst err",     32'(bus.md_timeout_err), 0);
        reset = 0;

        foreach (vecs[i]) begin
            set_dx(vecs[i].dx_valid, vecs[i].dx_rd, vecs[i].dx_is_lw, 0);
            set_fd(vecs[i].fd_rs, vecs[i].uses_rs, vecs[i].fd_rt, vecs[i].uses_rt,
                   vecs[i].is_bex, 0, 0, 0);
            exp_q.push_back(vecs[i].exp_stall);
            #1;
            check($sformatf("lu_vec%0d", i), 32'(bus.stall), 32'(exp_q.pop_front()));
        end

        // Load-use bubble: stall once, released when D/X becomes the bubble.
        idle_inputs(); set_dx(1, 5, 1, 0); set_fd(5, 1, 1, 1, 0, 0, 6, 1); #1;
        check("lu stall", 32'(bus.stall), 1);
        cycle_check("lu0");
        set_dx(0, 0, 0, 0); #1;
        check("lu release", 32'(bus.stall), 0);
        cycle_check("lu1");

        // mul r7 with a dependent add, result at cycle 17.
        idle_inputs(); set_dx(1, 7, 0, 1); set_fd(1, 1, 2, 1, 0, 0, 3, 1);
        cycle_check("mul go");
        check("mul start", 32'(bus.md_start), 1);
        check("mul pend7", bus.pending, 32'h80);
        check("mul busy",  32'(bus.md_busy), 1);
        set_dx(0, 0, 0, 0); set_fd(7, 1, 2, 1, 0, 0, 8, 1); #1;
        check("dep stall", 32'(bus.stall), 1);
        for (int i = 0; i < 16; i++) cycle_check("mul run");
        set_md(1, 0);
        cycle_check("mul rdy");
        set_md(0, 0); #1;
        check("wb stall", 32'(bus.stall), 1);
        check("wb valid", 32'(bus.md_wb_valid), 1);
        check("wb md_rd", 32'(bus.md_rd), 7);
        cycle_check("mul wb");
        check("post pend",  bus.pending, 0);
        check("post stall", 32'(bus.stall), 0);
        cycle_check("post");

        // div r9 raising an exception; bex blocked only during writeback.
        idle_inputs(); set_dx(1, 9, 0, 1);
        cycle_check("div go");
        set_dx(0, 0, 0, 0); set_fd(0, 0, 0, 0, 1, 0, 0, 0); #1;
        check("bex run", 32'(bus.stall), 0);
        for (int i = 0; i < 4; i++) cycle_check("div run");
        set_md(1, 1);
        cycle_check("div rdy");
        set_md(0, 0); #1;
        check("exc md_rd", 32'(bus.md_rd), 30);
        check("exc pend",  bus.pending, 32'h4000_0000);
        check("exc bex",   32'(bus.stall), 1);
        cycle_check("div wb");
        check("exc clear", bus.pending, 0);
        check("bex free",  32'(bus.stall), 0);
        cycle_check("div post");

        // Hazards while running; result in start cycle ignored; held mul in WB.
        idle_inputs(); set_dx(1, 7, 0, 1);
        cycle_check("h go");
        set_dx(0, 0, 0, 0); set_fd(1, 1, 2, 1, 0, 0, 3, 1); set_md(1, 0); #1;
        check("indep", 32'(bus.stall), 0);
        cycle_check("h early rdy");
        set_md(0, 0); #1;
        check("early busy", 32'(bus.md_busy), 1);
        check("early wb",   32'(bus.md_wb_valid), 0);
        set_fd(1, 1, 2, 1, 0, 1, 4, 1); #1;
        check("structural", 32'(bus.stall), 1);
        cycle_check("h struct");
        set_fd(1, 1, 2, 1, 0, 0, 7, 1); #1;
        check("waw", 32'(bus.stall), 1);
        cycle_check("h waw");
        set_fd(7, 0, 7, 0, 0, 0, 7, 0); #1;
        check("no use", 32'(bus.stall), 0);
        set_md(1, 0);
        cycle_check("h rdy");
        set_md(0, 0); set_dx(1, 4, 0, 1); #1;
        check("held stall", 32'(bus.stall), 1);
        cycle_check("h wb");
        check("held nostart", 32'(bus.md_start), 0);
        cycle_check("h restart");
        check("re start", 32'(bus.md_start), 1);
        check("re md_rd", 32'(bus.md_rd), 4);
        idle_inputs();
        cycle_check("h r1");
        set_md(1, 0);
        cycle_check("h r2");
        set_md(0, 0);
        cycle_check("h r3");

        // Timeout after MD_TIMEOUT run cycles without a result.
        idle_inputs(); set_dx(1, 7, 0, 1); set_fd(7, 1, 0, 0, 0, 0, 0, 0);
        cycle_check("to go");
        set_dx(0, 0, 0, 0);
        for (int i = 0; i < MD_TIMEOUT - 1; i++) cycle_check("to run");
        check("to busy39", 32'(bus.md_busy), 1);
        check("to err39",  32'(bus.md_timeout_err), 0);
        cycle_check("to last");
        check("to err",   32'(bus.md_timeout_err), 1);
        check("to busy",  32'(bus.md_busy), 0);
        check("to pend",  bus.pending, 0);
        check("to stall", 32'(bus.stall), 0);
        cycle_check("to idle");
        reset = 1;
        cycle_check("to rst");
        reset = 0; #1;
        check("to err clr", 32'(bus.md_timeout_err), 0);

        // Reset during a run; a late result must not produce a writeback.
        idle_inputs(); set_dx(1, 9, 0, 1);
        cycle_check("mr go");
        set_dx(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle_check("mr run");
        reset = 1;
        cycle_check("mr rst");
        reset = 0; #1;
        check("mr busy", 32'(bus.md_busy), 0);
        check("mr pend", bus.pending, 0);
        set_md(1, 0);
        cycle_check("mr late");
        set_md(0, 0); #1;
        check("mr nowb", 32'(bus.md_wb_valid), 0);
        cycle_check("mr idle");

        // Randomized traffic.
        quiet = 0;
        for (int n = 0; n < 1500; n++) begin
            int r;
            r = $urandom_range(0, 8);
            bus.dx_valid = 1'($urandom_range(0, 3) != 0);
            bus.dx_rd = REG_W'((r == 8) ? 30 : r);
            r = $urandom_range(0, 5);
            bus.dx_is_lw = (r == 0 || r == 1);
            bus.dx_is_muldiv = (r == 2);
            r = $urandom_range(0, 8);  bus.fd_rs = REG_W'((r == 8) ? 30 : r);
            r = $urandom_range(0, 8);  bus.fd_rt = REG_W'((r == 8) ? 30 : r);
            r = $urandom_range(0, 8);  bus.fd_rd = REG_W'((r == 8) ? 30 : r);
            bus.fd_uses_rs   = 1'($urandom_range(0, 1));
            bus.fd_uses_rt   = 1'($urandom_range(0, 1));
            bus.fd_writes    = 1'($urandom_range(0, 1));
            bus.fd_is_bex    = ($urandom_range(0, 7) == 0);
            bus.fd_is_muldiv = ($urandom_range(0, 5) == 0);
            if (quiet > 0) quiet--;
            else if ($urandom_range(0, 199) == 0) quiet = 60;
            bus.md_result_rdy = (quiet == 0) && ($urandom_range(0, 11) == 0);
            bus.md_exception  = ($urandom_range(0, 3) == 0);
            reset = ($urandom_range(0, 149) == 0);
            cycle_check("rand");
        end
        reset = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
